ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage directly downstream of the decode/execute pipeline register.
//  Consumes next_pc, funct4, rs and rt from that register and computes the ALU result.
//  Single-cycle ops complete in 1 cycle. MUL is a multi-cycle iterative shift-add that stalls upstream.
//  Drives a registered result/valid/zero/next_pc bundle toward the memory/writeback side.
// PARAMETERS
//  P  16  program-counter width
//  D  16  data width; also the MUL iteration count
//  F  4   funct4 opcode width
// PORTS
//  clk_i      in   1          single clock, rising edge
//  rst_i      in   1          synchronous reset, active-high
//  valid_i    in   1          instruction on *_i is valid this cycle
//  next_pc_i  in   P          next PC from D/E register
//  funct4_i   in   F          operation select
//  rs_i       in   D          operand A
//  rt_i       in   D          operand B; shift amount = rt_i[$clog2(D)-1:0]
//  stall_o    out  1          upstream must hold its current instruction; high iff state==MUL
//  valid_o    out  1          result bundle valid, 1-cycle pulse per instruction
//  next_pc_o  out  P          next_pc of the completed instruction
//  result_o   out  D          operation result
//  zero_o     out  1          result_o == 0
// BEHAVIOUR
//  - Reset, synchronous and active-high, dominates every condition.
//    Outputs after reset: state=IDLE, stall_o=0, valid_o=0, next_pc_o=0, result_o=0, zero_o=0.
//    Any MUL in flight is discarded.
//  - funct4 codes:
//    0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 ROL, 8 ROR, 9 MUL.
//    Codes A-F are reserved: result 0, still complete with valid_o=1.
//  - Arithmetic is modulo 2^D; carries are dropped.
//    MUL returns the low D bits of rs*rt (unsigned).
//    Shifts are logical. Rotates wrap within D bits. A shift amount of 0 passes rs through.
//  - FSM IDLE:
//    valid_i=0: valid_o<=0, stay in IDLE.
//    valid_i=1 with a single-cycle op: register result, next_pc and zero; valid_o<=1 next cycle.
//      Latency is 1, back-to-back throughput is 1 per cycle.
//    valid_i=1 with MUL: latch rs, rt and next_pc; clear acc and cnt; valid_o<=0; go to MUL.
//  - FSM MUL:
//    Each cycle: if mplier[0], acc+=mcand. Then mcand<<=1, mplier>>=1, cnt++.
//    When cnt==D-1, finish this iteration, then:
//      result_o<=acc_next, next_pc_o<=latched pc, valid_o<=1, go to IDLE.
//    Inputs are ignored while in MUL, including valid_i.
//    Accept to valid_o takes D+1 cycles. stall_o is high for exactly D cycles.
//  - stall_o is decoded from registered state only; there is no combinational path from inputs.
//    The instruction presented on the cycle after MUL accept is held by upstream.
//    It is consumed in the first IDLE cycle after stall_o falls.
//  - valid_o is never high while state==MUL. zero_o is updated only when valid_o is set.
//  - Reset asserted mid-MUL aborts the multiply. No valid_o pulse is emitted for it.
// STRUCTURE
//  - ex_pkg: funct4 enum (FN_ADD..FN_MUL), state enum {IDLE, MUL}, SHAMT_W = $clog2(D).
//  - Sub-module shift_add_mul holds the MUL iteration datapath and counter.
//    Ports: start, a, b -> busy, done, prod.
//  - Top level holds the FSM, the combinational single-cycle ALU and the output registers.
// TESTING (D=16)
//  - Reset mid-stream: assert rst_i during MUL cycle 5 -> next cycle all outputs 0, stall_o=0.
//    The held instruction is then accepted normally.
//  - ADD 0xFFFF+0x0002 -> result 0x0001, zero_o=0, valid_o 1 cycle later.
//    Then SUB 0x0005-0x0005 -> result 0, zero_o=1.
//  - Back-to-back ROL 0x8001,1 then SRL 0x8000,15 -> results 0x0003 then 0x0001 on consecutive cycles.
//  - MUL 0x0003*0x0005 -> stall_o high 16 cycles, valid_o at accept+17, result 0x000F.
//    MUL 0xFFFF*0xFFFF -> result 0x0001.
//  - MUL followed by ADD held under stall -> ADD result appears the cycle after the MUL result.
//    The ADD is not duplicated or lost.
//  - Reserved funct4 0xF with any operands -> valid_o=1, result_o=0, zero_o=1.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: opcode and FSM encodings,
// default widths and the shift-amount width derived from the data width.
package ex_pkg;

  localparam int P_W     = 16;
  localparam int D_W     = 16;
  localparam int F_W     = 4;
  localparam int SHAMT_W = $clog2(D_W);

  typedef enum logic [3:0] {
    FN_ADD = 4'h0,
    FN_SUB = 4'h1,
    FN_AND = 4'h2,
    FN_OR  = 4'h3,
    FN_XOR = 4'h4,
    FN_SLL = 4'h5,
    FN_SRL = 4'h6,
    FN_ROL = 4'h7,
    FN_ROR = 4'h8,
    FN_MUL = 4'h9
  } fn_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/ex_if.sv
// Bundle between the D/E register (master) and the execute stage (slave):
// instruction fields in, stall and registered result bundle out.
interface ex_if
  import ex_pkg::*;
#(
  parameter int P = P_W,
  parameter int D = D_W,
  parameter int F = F_W
);

  logic         valid_i;
  logic [P-1:0] next_pc_i;
  logic [F-1:0] funct4_i;
  logic [D-1:0] rs_i;
  logic [D-1:0] rt_i;
  logic         stall_o;
  logic         valid_o;
  logic [P-1:0] next_pc_o;
  logic [D-1:0] result_o;
  logic         zero_o;

  modport master (
    output valid_i, next_pc_i, funct4_i, rs_i, rt_i,
    input  stall_o, valid_o, next_pc_o, result_o, zero_o
  );

  modport slave (
    input  valid_i, next_pc_i, funct4_i, rs_i, rt_i,
    output stall_o, valid_o, next_pc_o, result_o, zero_o
  );

endinterface

// File: rtl/ex_stage_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, D iterations.
// prod is the accumulator value after the current iteration; done flags the last one.
module shift_add_mul
  import ex_pkg::*;
#(
  parameter int D  = D_W,
  parameter int CW = SHAMT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [D-1:0] prod
);

  logic [D-1:0]  mcand;
  logic [D-1:0]  mplier;
  logic [D-1:0]  acc;
  logic [D-1:0]  acc_next;
  logic [CW-1:0] cnt;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // Raw iteration count; the caller qualifies it with busy.
  assign done = (cnt == CW'(D - 1));
  assign prod = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU with 1-cycle latency, MUL via iterative
// multiplier that holds upstream through stall_o for exactly D cycles.
module ex_stage
  import ex_pkg::*;
#(
  parameter int P = P_W,
  parameter int D = D_W,
  parameter int F = F_W
) (
  input logic clk_i,
  input logic rst_i,
  ex_if.slave bus
);

  localparam int SH = $clog2(D);

  state_e        state;
  logic [P-1:0]  pc_lat;
  logic [P-1:0]  next_pc_q;
  logic [D-1:0]  result_q;
  logic          valid_q;
  logic          zero_q;
  logic [D-1:0]  alu;
  logic [SH-1:0] shamt;
  logic          is_mul;
  logic          mul_start;
  logic          mul_busy;
  logic          mul_done;
  logic [D-1:0]  mul_prod;

  always_comb begin
    alu   = '0;
    shamt = bus.rt_i[SH-1:0];
    case (bus.funct4_i)
      FN_ADD:  alu = bus.rs_i + bus.rt_i;
      FN_SUB:  alu = bus.rs_i - bus.rt_i;
      FN_AND:  alu = bus.rs_i & bus.rt_i;
      FN_OR:   alu = bus.rs_i | bus.rt_i;
      FN_XOR:  alu = bus.rs_i ^ bus.rt_i;
      FN_SLL:  alu = bus.rs_i << shamt;
      FN_SRL:  alu = bus.rs_i >> shamt;
      // A shift by the full width yields zero, so shamt==0 passes rs through.
      FN_ROL:  alu = (bus.rs_i << shamt) | (bus.rs_i >> (D - int'(shamt)));
      FN_ROR:  alu = (bus.rs_i >> shamt) | (bus.rs_i << (D - int'(shamt)));
      default: alu = '0;
    endcase
  end

  assign is_mul    = (bus.funct4_i == FN_MUL);
  assign mul_start = (state == IDLE) && bus.valid_i && is_mul;

  shift_add_mul #(
    .D  (D),
    .CW (SH)
  ) u_mul (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (mul_start),
    .a     (bus.rs_i),
    .b     (bus.rt_i),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      next_pc_q <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      pc_lat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.valid_i) begin
            if (is_mul) begin
              pc_lat <= bus.next_pc_i;
              state  <= MUL;
            end else begin
              valid_q   <= 1'b1;
              result_q  <= alu;
              zero_q    <= (alu == '0);
              next_pc_q <= bus.next_pc_i;
            end
          end
        end
        MUL: begin
          valid_q <= 1'b0;
          if (mul_busy && mul_done) begin
            valid_q   <= 1'b1;
            result_q  <= mul_prod;
            zero_q    <= (mul_prod == '0);
            next_pc_q <= pc_lat;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_o   = (state == MUL);
  assign bus.valid_o   = valid_q;
  assign bus.next_pc_o = next_pc_q;
  assign bus.result_o  = result_q;
  assign bus.zero_o    = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Random and directed instruction stream for ex_stage, checked every cycle
// against a cycle-indexed table of expected outputs built from plain arithmetic.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_if bus ();

  ex_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int free_edge   = 0;

  bit          exp_vld  [MAXC];
  bit          exp_stall[MAXC];
  bit          exp_rst  [MAXC];
  bit          exp_zero [MAXC];
  logic [15:0] exp_res  [MAXC];
  logic [15:0] exp_pc   [MAXC];
  bit          lit_on   [MAXC];
  bit          lit_zero [MAXC];
  logic [15:0] lit_res  [MAXC];

  function automatic logic [15:0] model(input int fn, input int unsigned a, input int unsigned b);
    int unsigned s;
    int unsigned pw;
    int unsigned pwc;
    longint unsigned p;
    s   = b % 16;
    pw  = 32'd1 << s;
    pwc = 32'd1 << (16 - s);
    case (fn)
      0: return 16'((a + b) % 65536);
      1: return 16'((a + 65536 - b) % 65536);
      2: return 16'(a & b);
      3: return 16'(a | b);
      4: return 16'(a ^ b);
      5: return 16'((a * pw) % 65536);
      6: return 16'(a / pw);
      7: return 16'((a * pw) % 65536 + a / pwc);
      8: return 16'(a / pw + (a * pwc) % 65536);
      9: begin
        p = longint'(a) * longint'(b);
        return 16'(p % 65536);
      end
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string name, input int n, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h, want %h", name, n, got, want);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC) begin
        if (exp_rst[cyc]) begin
          chk("rst_valid", cyc, 32'(bus.valid_o), 0);
          chk("rst_stall", cyc, 32'(bus.stall_o), 0);
          chk("rst_result", cyc, 32'(bus.result_o), 0);
          chk("rst_pc", cyc, 32'(bus.next_pc_o), 0);
          chk("rst_zero", cyc, 32'(bus.zero_o), 0);
        end else begin
          chk("stall", cyc, 32'(bus.stall_o), 32'(exp_stall[cyc]));
          chk("valid", cyc, 32'(bus.valid_o), 32'(exp_vld[cyc]));
          if (exp_vld[cyc]) begin
            chk("result", cyc, 32'(bus.result_o), 32'(exp_res[cyc]));
            chk("next_pc", cyc, 32'(bus.next_pc_o), 32'(exp_pc[cyc]));
            chk("zero", cyc, 32'(bus.zero_o), 32'(exp_zero[cyc]));
          end
          if (lit_on[cyc]) begin
            chk("lit_result", cyc, 32'(bus.result_o), 32'(lit_res[cyc]));
            chk("lit_zero", cyc, 32'(bus.zero_o), 32'(lit_zero[cyc]));
          end
        end
      end
    end
  end

  // Presents inputs for the next rising edge and records what that edge must produce.
  task automatic edge_step(input bit rb, input bit v, input logic [3:0] fn, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] pc, output bit acc, output int w);
    int e;
    logic [15:0] r;
    e             = cyc + 1;
    acc           = 1'b0;
    w             = -1;
    rst           = rb;
    bus.valid_i   = v;
    bus.funct4_i  = fn;
    bus.rs_i      = a;
    bus.rt_i      = b;
    bus.next_pc_i = pc;
    if (e + 20 < MAXC) begin
      if (rb) begin
        for (int k = e; k < e + 20; k++) begin
          exp_vld[k]   = 1'b0;
          exp_stall[k] = 1'b0;
          exp_rst[k]   = 1'b0;
          lit_on[k]    = 1'b0;
        end
        exp_rst[e] = 1'b1;
        free_edge  = e + 1;
      end else if (v && e >= free_edge) begin
        acc = 1'b1;
        r   = model(int'(fn), 32'(a), 32'(b));
        if (fn == 4'h9) begin
          for (int k = e; k < e + 16; k++) exp_stall[k] = 1'b1;
          w         = e + 16;
          free_edge = e + 17;
        end else begin
          w         = e;
          free_edge = e + 1;
        end
        exp_vld[w]  = 1'b1;
        exp_res[w]  = r;
        exp_pc[w]   = pc;
        exp_zero[w] = (r == 16'h0000);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Holds one instruction on the inputs until it is accepted.
  task automatic issue(input bit v, input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] pc, input bit rr, output int w);
    bit acc;
    int ww;
    do begin
      if (rr && $urandom_range(0, 149) == 0) edge_step(1'b1, v, fn, a, b, pc, acc, ww);
      else edge_step(1'b0, v, fn, a, b, pc, acc, ww);
    end while (v && !acc && cyc < MAXC - 40);
    w = ww;
  endtask

  task automatic set_lit(input int w, input logic [15:0] res, input bit z);
    if (w >= 0 && w < MAXC) begin
      lit_on[w]   = 1'b1;
      lit_res[w]  = res;
      lit_zero[w] = z;
    end
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int w;
    bit acc;
    int x;
    logic [3:0] fn;
    edge_step(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, acc, w);
    edge_step(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, acc, w);

    issue(1'b1, 4'h0, 16'hFFFF, 16'h0002, 16'h0100, 1'b0, w); set_lit(w, 16'h0001, 1'b0);
    issue(1'b1, 4'h1, 16'h0005, 16'h0005, 16'h0102, 1'b0, w); set_lit(w, 16'h0000, 1'b1);
    issue(1'b1, 4'h7, 16'h8001, 16'h0001, 16'h0104, 1'b0, w); set_lit(w, 16'h0003, 1'b0);
    issue(1'b1, 4'h6, 16'h8000, 16'h000F, 16'h0106, 1'b0, w); set_lit(w, 16'h0001, 1'b0);
    issue(1'b1, 4'h9, 16'h0003, 16'h0005, 16'h0108, 1'b0, w); set_lit(w, 16'h000F, 1'b0);
    issue(1'b1, 4'h9, 16'hFFFF, 16'hFFFF, 16'h010A, 1'b0, w); set_lit(w, 16'h0001, 1'b0);
    issue(1'b1, 4'h9, 16'h0007, 16'h0009, 16'h010C, 1'b0, w); set_lit(w, 16'h003F, 1'b0);
    issue(1'b1, 4'h0, 16'h0001, 16'h0002, 16'h010E, 1'b0, w); set_lit(w, 16'h0003, 1'b0);
    issue(1'b1, 4'h5, 16'h1234, 16'h0000, 16'h0110, 1'b0, w); set_lit(w, 16'h1234, 1'b0);

    // MUL aborted by reset in its fifth cycle while an ADD waits behind it.
    issue(1'b1, 4'h9, 16'h1234, 16'h0010, 16'h0200, 1'b0, w);
    for (int i = 0; i < 4; i++) edge_step(1'b0, 1'b1, 4'h0, 16'h0010, 16'h0020, 16'h0202, acc, w);
    edge_step(1'b1, 1'b1, 4'h0, 16'h0010, 16'h0020, 16'h0202, acc, w);
    issue(1'b1, 4'h0, 16'h0010, 16'h0020, 16'h0202, 1'b0, w); set_lit(w, 16'h0030, 1'b0);

    issue(1'b1, 4'hF, 16'($urandom), 16'($urandom), 16'h0300, 1'b0, w); set_lit(w, 16'h0000, 1'b1);

    for (int i = 0; i < 400 && cyc < MAXC - 100; i++) begin
      x = $urandom_range(0, 19);
      if (x < 10) fn = 4'(x);
      else if (x < 13) fn = 4'h9;
      else if (x < 15) fn = 4'($urandom_range(10, 15));
      else fn = 4'($urandom_range(0, 8));
      issue(($urandom_range(0, 5) != 0), fn, rnd_op(), rnd_op(), 16'($urandom), 1'b1, w);
    end

    for (int i = 0; i < 20; i++) edge_step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, acc, w);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
